// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM encoding and baud divider.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per bit period (integer division, truncating).
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for one asynchronous bit; both flops reset to RESET_VAL.
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling driven purely by a bit counter.
//
// Output semantics: uart_rx_done is a one-cycle valid strobe with no ready;
// uart_rx_data is valid in the cycle uart_rx_done is high and is held until the
// next good frame. uart_frame_err is a one-cycle strobe for a low stop bit and
// never coincides with uart_rx_done.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       uart_rx_done,
  output logic [7:0] uart_rx_data,
  output logic       uart_frame_err,
  output logic       uart_rx_busy
);

  localparam int BAUD_CNT = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT - 1);

  generate
    if (BAUD_CNT < 4) begin : g_baud_check
      $error("uart_byte_receiver: BAUD_CNT must be at least 4");
    end
  endgenerate

  rx_state_t        state;
  rx_state_t        state_next;
  logic             rxd_sync;
  logic             rxd_hist;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift_reg;
  logic             half_hit;
  logic             bit_hit;

  bit_synchronizer #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_sync)
  );

  // History flop for falling-edge detection on the synchronised line.
  always_ff @(posedge clk) begin
    if (rst) rxd_hist <= 1'b1;
    else     rxd_hist <= rxd_sync;
  end

  assign fall     = rxd_hist & ~rxd_sync;
  assign half_hit = (cnt == CNT_HALF);
  assign bit_hit  = (cnt == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start validated at half bit, then whole-bit steps.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (fall) state_next = ST_START;
      ST_START: if (half_hit) state_next = rxd_sync ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_hit && idx == 3'd7) state_next = ST_STOP;
      ST_STOP:  if (bit_hit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Bit-timing counter; held at zero in IDLE so START always begins from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_START:         cnt <= half_hit ? '0 : cnt + 1'b1;
        ST_DATA, ST_STOP: cnt <= bit_hit  ? '0 : cnt + 1'b1;
        default:          cnt <= '0;
      endcase
    end
  end

  // Data bit index; cleared while validating the start bit.
  always_ff @(posedge clk) begin
    if (rst)                          idx <= 3'd0;
    else if (state == ST_START)       idx <= 3'd0;
    else if (state == ST_DATA && bit_hit) idx <= idx + 3'd1;
  end

  // Shift register filled LSB first at each data mid-bit.
  always_ff @(posedge clk) begin
    if (rst)                              shift_reg <= 8'h00;
    else if (state == ST_DATA && bit_hit) shift_reg[idx] <= rxd_sync;
  end

  // Result strobes and held byte, decided at the stop-bit mid-sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_rx_done   <= 1'b0;
      uart_frame_err <= 1'b0;
      uart_rx_data   <= 8'h00;
    end else begin
      uart_rx_done   <= 1'b0;
      uart_frame_err <= 1'b0;
      if (state == ST_STOP && bit_hit) begin
        if (rxd_sync) begin
          uart_rx_done <= 1'b1;
          uart_rx_data <= shift_reg;
        end else begin
          uart_frame_err <= 1'b1;
        end
      end
    end
  end

  assign uart_rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at BAUD_CNT=10, HALF_CNT=5.
module tb_uart_byte_receiver;

  localparam int BAUD = 10;
  localparam int HALF = 5;
  // Two synchroniser stages between the pin and the edge detector.
  localparam int LAT  = 2 + HALF + 9 * BAUD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int busy_cnt = 0;
  int inv_err  = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         err_cyc_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  uart_byte_receiver #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rxd       (uart_rxd),
    .uart_rx_done   (uart_rx_done),
    .uart_rx_data   (uart_rx_data),
    .uart_frame_err (uart_frame_err),
    .uart_rx_busy   (uart_rx_busy)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: collect strobes and track invariants.
  always @(negedge clk) begin
    if (uart_rx_done) begin
      got_q.push_back(uart_rx_data);
      got_cyc_q.push_back(cyc);
    end
    if (uart_frame_err) err_cyc_q.push_back(cyc);
    if (uart_rx_busy) busy_cnt++;
    if (uart_rx_done && uart_frame_err) inv_err++;
    if (uart_rx_done && prev_done) inv_err++;
    if (uart_frame_err && prev_err) inv_err++;
    prev_done = uart_rx_done;
    prev_err  = uart_frame_err;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    err_cyc_q.delete();
    busy_cnt = 0;
  endtask

  // Drive one full frame; the line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd  = 1'b0;
    start_cyc = cyc;
    wait_cycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cycles(BAUD);
    end
    uart_rxd = stop_bit;
    wait_cycles(BAUD);
  endtask

  // Compare collected bytes against the expected queue.
  task automatic check_bytes(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_byte"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    vecs[0] = '{8'h35, 1'b1, 1, 0, 8'h35};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // Reset.
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_done", uart_rx_done, 1'b0);
    check("reset_err", uart_frame_err, 1'b0);
    check("reset_data", uart_rx_data, 8'h00);
    check("reset_busy", uart_rx_busy, 1'b0);
    wait_cycles(5);

    // Single frames from the table.
    for (int v = 0; v < 5; v++) begin
      clear_scoreboard();
      if (vecs[v].exp_done != 0) exp_q.push_back(vecs[v].exp_data);
      send_byte(vecs[v].data, vecs[v].stop);
      uart_rxd = 1'b1;
      wait_cycles(20);
      check_bytes($sformatf("vec%0d", v));
      check($sformatf("vec%0d_err", v), err_cyc_q.size(), vecs[v].exp_err);
      check($sformatf("vec%0d_data", v), uart_rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_busy", v), uart_rx_busy, 1'b0);
      if (vecs[v].exp_done != 0 && got_cyc_q.size() > 0)
        check($sformatf("vec%0d_latency", v), got_cyc_q[0] - start_cyc, LAT);
      if (vecs[v].exp_err != 0 && err_cyc_q.size() > 0)
        check($sformatf("vec%0d_err_latency", v), err_cyc_q[0] - start_cyc, LAT);
    end

    // Back-to-back '1' then '2' with no idle gap.
    clear_scoreboard();
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    wait_cycles(20);
    check_bytes("b2b");
    check("b2b_err", err_cyc_q.size(), 0);
    if (got_cyc_q.size() == 2)
      check("b2b_spacing", got_cyc_q[1] - got_cyc_q[0], 10 * BAUD);

    // Three-cycle glitch must be rejected at the start-bit check.
    clear_scoreboard();
    uart_rxd = 1'b0;
    wait_cycles(3);
    uart_rxd = 1'b1;
    wait_cycles(20);
    check("glitch_done", got_q.size(), 0);
    check("glitch_err", err_cyc_q.size(), 0);
    check("glitch_busy_cycles", busy_cnt, HALF);
    check("glitch_data", uart_rx_data, 8'h32);

    // Bad stop bit, then line held low, then a clean frame.
    clear_scoreboard();
    send_byte(8'hA5, 1'b0);
    wait_cycles(30);
    check("ferr_count", err_cyc_q.size(), 1);
    check("ferr_done", got_q.size(), 0);
    check("ferr_data_held", uart_rx_data, 8'h32);
    if (err_cyc_q.size() > 0)
      check("ferr_latency", err_cyc_q[0] - start_cyc, LAT);
    check("break_busy", uart_rx_busy, 1'b0);
    uart_rxd = 1'b1;
    wait_cycles(10);
    exp_q.push_back(8'h39);
    send_byte(8'h39, 1'b1);
    wait_cycles(20);
    check_bytes("after_break");
    check("after_break_err", err_cyc_q.size(), 1);

    // Reset in the middle of data bit 4 of 8'h37 aborts the frame.
    clear_scoreboard();
    uart_rxd = 1'b0;
    wait_cycles(BAUD);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = (8'h37 >> i) & 1;
      wait_cycles(BAUD);
    end
    uart_rxd = 1'b1;
    wait_cycles(HALF);
    @(negedge clk);
    check("midframe_busy", uart_rx_busy, 1'b1);
    #1;
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_done", uart_rx_done, 1'b0);
    check("rst_mid_err", uart_frame_err, 1'b0);
    check("rst_mid_data", uart_rx_data, 8'h00);
    check("rst_mid_busy", uart_rx_busy, 1'b0);
    wait_cycles(3 * BAUD);
    check("rst_mid_no_pulse", got_q.size() + err_cyc_q.size(), 0);
    exp_q.push_back(8'h36);
    send_byte(8'h36, 1'b1);
    wait_cycles(20);
    check_bytes("after_rst");
    check("after_rst_data", uart_rx_data, 8'h36);

    check("strobe_invariants", inv_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
